// File: rtl/calc_result_sequencer.sv
// ---------------------------------------------------------------------------
// calc_result_sequencer
// Runs one calculator operation end to end. It latches the operands and opcode
// when start is accepted and pulses alu_go. It waits ALU_LAT edges for the ALU,
// then captures the result and flags. It converts the 8-bit result to BCD with a
// serial shift-add-3 that handles one bit per cycle. Finally it publishes the
// digits and flags together with a one-cycle done pulse.
//
// Ports
//   clock, reset          : system clock; synchronous active-high reset
//   start                 : level request, honoured only while idle
//   operand_a/b, opcode   : operation inputs, sampled on the accepting edge
//   alu_result/overflow/carry : ALU response, sampled ALU_LAT edges after launch
//   alu_a/b, alu_op       : registered operands/opcode to the ALU
//   alu_go                : one-cycle ALU launch pulse
//   busy                  : high in every state except idle
//   done                  : one-cycle pulse, display outputs valid from this cycle
//   Units/Tens/Hundreds   : BCD digits of the last published result
//   Zero/Overflow/Carry_out : flags of the last published result
// ---------------------------------------------------------------------------
module calc_result_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic [1:0] opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_go,
    output logic       busy,
    output logic       done,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow,
    output logic       Carry_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_CONVERT = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(ALU_LAT - 1);
    localparam logic [3:0] BIT_LAST  = 4'd7;

    // Add-3 correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;          // wait counter in WAIT, bit counter in CONVERT
    logic [7:0]  result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        carry_q, carry_d;
    // {hundreds[1:0], tens[3:0], units[3:0], binary[7:0]}
    logic [17:0] bcd_q, bcd_d;
    logic [17:0] conv_s;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        alu_go_q, alu_go_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  units_q, units_d;
    logic [3:0]  tens_q, tens_d;
    logic [1:0]  hund_q, hund_d;
    logic        zero_q, zero_d;
    logic        ovf_out_q, ovf_out_d;
    logic        carry_out_q, carry_out_d;

    // One double-dabble iteration: correct units/tens, then shift left by one.
    // Hundreds never exceeds 2, so it needs no correction.
    always_comb begin
        conv_s = {bcd_q[16], add3(bcd_q[15:12]), add3(bcd_q[11:8]), bcd_q[7:0], 1'b0};
    end

    // Next-state and output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        bcd_d       = bcd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_go_d    = 1'b0;
        done_d      = 1'b0;
        units_d     = units_q;
        tens_d      = tens_q;
        hund_d      = hund_q;
        zero_d      = zero_q;
        ovf_out_d   = ovf_out_q;
        carry_out_d = carry_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LAUNCH;
                    alu_a_d  = operand_a;
                    alu_b_d  = operand_b;
                    alu_op_d = opcode;
                    alu_go_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = 4'd0;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    result_d = alu_result;
                    ovf_d    = alu_overflow;
                    carry_d  = alu_carry;
                    bcd_d    = {10'd0, alu_result};
                    cnt_d    = 4'd0;
                    state_d  = S_CONVERT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CONVERT: begin
                bcd_d = conv_s;
                if (cnt_q == BIT_LAST) begin
                    units_d     = conv_s[11:8];
                    tens_d      = conv_s[15:12];
                    hund_d      = conv_s[17:16];
                    zero_d      = (result_q == 8'd0);
                    ovf_out_d   = ovf_q;
                    carry_out_d = carry_q;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset; display resets to 000.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            result_q    <= 8'd0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            bcd_q       <= 18'd0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_op_q    <= 2'd0;
            alu_go_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            hund_q      <= 2'd0;
            zero_q      <= 1'b1;
            ovf_out_q   <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
            bcd_q       <= bcd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_go_q    <= alu_go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            units_q     <= units_d;
            tens_q      <= tens_d;
            hund_q      <= hund_d;
            zero_q      <= zero_d;
            ovf_out_q   <= ovf_out_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_go    = alu_go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign Units     = units_q;
    assign Tens      = tens_q;
    assign Hundreds  = hund_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_out_q;
    assign Carry_out = carry_out_q;

endmodule

// File: tb/tb_calc_result_sequencer.sv
// Bench for calc_result_sequencer: one instance with ALU latency 1 and one with
// ALU latency 3, each driven by an A+B ALU model. Digits and flags are checked
// against decimal arithmetic.
module tb_calc_result_sequencer;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Instance with ALU latency 1.
    logic       reset1, start1;
    logic [7:0] operand_a1, operand_b1;
    logic [1:0] opcode1;
    logic [7:0] alu_result1;
    logic       alu_overflow1, alu_carry1;
    logic [7:0] alu_a1, alu_b1;
    logic [1:0] alu_op1;
    logic       alu_go1, busy1, done1;
    logic [3:0] units1, tens1;
    logic [1:0] hund1;
    logic       zero1, ovf1, cout1;
    logic [8:0] sum1;

    // Instance with ALU latency 3.
    logic       reset3, start3;
    logic [7:0] operand_a3, operand_b3;
    logic [1:0] opcode3;
    logic [7:0] alu_result3;
    logic       alu_overflow3, alu_carry3;
    logic [7:0] alu_a3, alu_b3;
    logic [1:0] alu_op3;
    logic       alu_go3, busy3, done3;
    logic [3:0] units3, tens3;
    logic [1:0] hund3;
    logic       zero3, ovf3, cout3;
    logic [8:0] sum3;

    // ALU models: 8-bit add with carry and signed overflow.
    assign sum1          = {1'b0, alu_a1} + {1'b0, alu_b1};
    assign alu_result1   = sum1[7:0];
    assign alu_carry1    = sum1[8];
    assign alu_overflow1 = (alu_a1[7] == alu_b1[7]) && (sum1[7] != alu_a1[7]);
    assign sum3          = {1'b0, alu_a3} + {1'b0, alu_b3};
    assign alu_result3   = sum3[7:0];
    assign alu_carry3    = sum3[8];
    assign alu_overflow3 = (alu_a3[7] == alu_b3[7]) && (sum3[7] != alu_a3[7]);

    calc_result_sequencer #(.ALU_LAT(LAT1)) dut1 (
        .clock(clock), .reset(reset1), .start(start1),
        .operand_a(operand_a1), .operand_b(operand_b1), .opcode(opcode1),
        .alu_result(alu_result1), .alu_overflow(alu_overflow1), .alu_carry(alu_carry1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_go(alu_go1),
        .busy(busy1), .done(done1), .Units(units1), .Tens(tens1), .Hundreds(hund1),
        .Zero(zero1), .Overflow(ovf1), .Carry_out(cout1)
    );

    calc_result_sequencer #(.ALU_LAT(LAT3)) dut3 (
        .clock(clock), .reset(reset3), .start(start3),
        .operand_a(operand_a3), .operand_b(operand_b3), .opcode(opcode3),
        .alu_result(alu_result3), .alu_overflow(alu_overflow3), .alu_carry(alu_carry3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_go(alu_go3),
        .busy(busy3), .done(done3), .Units(units3), .Tens(tens3), .Hundreds(hund3),
        .Zero(zero3), .Overflow(ovf3), .Carry_out(cout3)
    );

    // Reference: signed 8-bit overflow of a+b using integer arithmetic.
    function automatic logic ref_ovf(input int a, input int b);
        int sa, sb, s;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        s  = sa + sb;
        return (s > 127) || (s < -128);
    endfunction

    // Compare published display of dut1 against decimal digits of (a+b) mod 256.
    task automatic check_display1(input string name, input int a, input int b);
        int r;
        r = (a + b) % 256;
        checks++;
        if ({hund1, tens1, units1} !== {2'(r / 100), 4'((r / 10) % 10), 4'(r % 10)}) begin
            errors++;
            $display("FAIL %s digits: got %0d/%0d/%0d want %0d/%0d/%0d", name,
                     hund1, tens1, units1, r / 100, (r / 10) % 10, r % 10);
        end
        checks++;
        if ({zero1, ovf1, cout1} !== {(r == 0), ref_ovf(a, b), (a + b > 255)}) begin
            errors++;
            $display("FAIL %s flags Z/O/C: got %b%b%b want %b%b%b", name, zero1, ovf1, cout1,
                     (r == 0), ref_ovf(a, b), (a + b > 255));
        end
    endtask

    // Run one op on dut1 and observe for 15 cycles after the accepting edge.
    // Optionally re-pulse start at cycles 3 and 6 and scramble operands while busy.
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic repulse, output int first_done, output int n_done,
                       output int n_go);
        operand_a1 = a;
        operand_b1 = b;
        opcode1    = op;
        start1     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start1     = 1'b0;
        first_done = -1;
        n_done     = 0;
        n_go       = alu_go1 ? 1 : 0;
        if (done1) n_done++;
        for (int k = 1; k <= 14; k++) begin
            start1     = repulse && (k == 3 || k == 6);
            operand_a1 = repulse ? 8'($urandom) : a;
            operand_b1 = repulse ? 8'($urandom) : b;
            @(posedge clock);
            @(negedge clock);
            if (alu_go1) n_go++;
            if (done1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({alu_a1, alu_b1, alu_op1, alu_go1, busy1, done1, units1, tens1, hund1, ovf1, cout1} !== 37'd0
            || zero1 !== 1'b1) begin
            errors++;
            $display("FAIL reset1: got outputs nonzero or Zero=%b, want all 0 and Zero=1", zero1);
        end
        checks++;
        if ({alu_a3, alu_b3, alu_op3, alu_go3, busy3, done3, units3, tens3, hund3, ovf3, cout3} !== 37'd0
            || zero3 !== 1'b1) begin
            errors++;
            $display("FAIL reset3: got outputs nonzero or Zero=%b, want all 0 and Zero=1", zero3);
        end
    endtask

    task automatic test_basic;
        int fd, nd, ng;
        op1(8'd200, 8'd55, 2'd2, 1'b0, fd, nd, ng);
        checks++;
        if (fd !== LAT1 + 9) begin errors++; $display("FAIL basic latency: got %0d want %0d", fd, LAT1 + 9); end
        checks++;
        if (nd !== 1 || ng !== 1) begin errors++; $display("FAIL basic pulses: done=%0d go=%0d want 1/1", nd, ng); end
        checks++;
        if (alu_op1 !== 2'd2 || alu_a1 !== 8'd200 || alu_b1 !== 8'd55) begin
            errors++; $display("FAIL basic latch: a=%0d b=%0d op=%0d want 200/55/2", alu_a1, alu_b1, alu_op1);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL basic idle busy: got %b want 0", busy1); end
        check_display1("basic", 200, 55);
    endtask

    task automatic test_zero;
        int fd, nd, ng;
        op1(8'd0, 8'd0, 2'd0, 1'b0, fd, nd, ng);
        check_display1("zero", 0, 0);
        op1(8'd9, 8'd1, 2'd0, 1'b0, fd, nd, ng);
        check_display1("ten", 9, 1);
    endtask

    task automatic test_busy_ignore;
        int fd, nd, ng;
        op1(8'd17, 8'd30, 2'd1, 1'b1, fd, nd, ng);
        checks++;
        if (nd !== 1 || ng !== 1 || fd !== LAT1 + 9) begin
            errors++; $display("FAIL busy_ignore pulses: done=%0d go=%0d lat=%0d want 1/1/%0d", nd, ng, fd, LAT1 + 9);
        end
        checks++;
        if (alu_a1 !== 8'd17) begin errors++; $display("FAIL busy_ignore alu_a: got %0d want 17", alu_a1); end
        check_display1("busy_ignore", 17, 30);
    endtask

    task automatic test_flags;
        int fd, nd, ng;
        op1(8'd128, 8'd128, 2'd0, 1'b0, fd, nd, ng);
        checks++;
        if (ovf1 !== 1'b1 || cout1 !== 1'b1) begin
            errors++; $display("FAIL flags set: O=%b C=%b want 1/1", ovf1, cout1);
        end
        check_display1("flags_set", 128, 128);
        op1(8'd1, 8'd2, 2'd0, 1'b0, fd, nd, ng);
        check_display1("flags_clear", 1, 2);
    endtask

    task automatic test_reset_mid;
        int fd, nd, ng, stray;
        operand_a1 = 8'd100;
        operand_b1 = 8'd23;
        start1     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start1 = 1'b0;
        repeat (5) begin @(posedge clock); @(negedge clock); end
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_mid busy before reset: got %b want 1", busy1); end
        reset1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || {hund1, tens1, units1} !== 10'd0 || zero1 !== 1'b1
            || alu_a1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid state: busy=%b done=%b digits=%0d/%0d/%0d Z=%b a=%0d want 0 0 0/0/0 1 0",
                     busy1, done1, hund1, tens1, units1, zero1, alu_a1);
        end
        stray = 0;
        repeat (14) begin @(posedge clock); @(negedge clock); if (done1) stray++; end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL reset_mid stray done: got %0d want 0", stray); end
        op1(8'd100, 8'd23, 2'd3, 1'b0, fd, nd, ng);
        checks++;
        if (fd !== LAT1 + 9 || nd !== 1) begin errors++; $display("FAIL reset_mid recover: lat=%0d done=%0d", fd, nd); end
        check_display1("reset_mid_recover", 100, 23);
    endtask

    task automatic test_reset_priority;
        operand_a1 = 8'd77;
        start1     = 1'b1;
        reset1     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset1 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || alu_go1 !== 1'b0 || alu_a1 !== 8'd0) begin
            errors++; $display("FAIL reset_priority: busy=%b go=%b a=%0d want 0/0/0", busy1, alu_go1, alu_a1);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_random;
        int fd, nd, ng;
        logic [7:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op1(a, b, 2'($urandom), 1'b0, fd, nd, ng);
            checks++;
            if (fd !== LAT1 + 9 || nd !== 1 || ng !== 1) begin
                errors++; $display("FAIL random[%0d] timing: lat=%0d done=%0d go=%0d", i, fd, nd, ng);
            end
            check_display1("random", int'(a), int'(b));
        end
    endtask

    task automatic test_back_to_back;
        int got[$];
        int exp[$];
        int idle_from;
        idle_from = 0;
        // Expected done edges: accept whenever idle and start high; done LAT+9 edges later.
        for (int k = 0; k <= 34; k++) begin
            if (k >= idle_from) begin
                exp.push_back(k + LAT3 + 9);
                idle_from = k + LAT3 + 10;
            end
        end
        operand_a3 = 8'd60;
        operand_b3 = 8'd5;
        opcode3    = 2'd0;
        start3     = 1'b1;
        for (int k = 0; k <= 55; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done3) got.push_back(k);
            start3 = (k < 34);
        end
        start3 = 1'b0;
        checks++;
        if (got.size() !== exp.size()) begin
            errors++; $display("FAIL b2b done count: got %0d want %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++; $display("FAIL b2b done[%0d] edge: got %0d want %0d", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_sweep;
        int a, b, lat;
        for (int r = 0; r < 256; r++) begin
            a = $urandom_range(0, r);
            b = r - a;
            operand_a3 = 8'(a);
            operand_b3 = 8'(b);
            start3     = 1'b1;
            @(posedge clock);
            @(negedge clock);
            start3 = 1'b0;
            lat    = -1;
            for (int k = 1; k <= 40 && lat < 0; k++) begin
                @(posedge clock);
                @(negedge clock);
                if (done3) lat = k;
            end
            checks++;
            if (lat !== LAT3 + 9) begin
                errors++; $display("FAIL sweep[%0d] latency: got %0d want %0d", r, lat, LAT3 + 9);
            end
            checks++;
            if ({hund3, tens3, units3} !== {2'(r / 100), 4'((r / 10) % 10), 4'(r % 10)}
                || zero3 !== (r == 0) || ovf3 !== ref_ovf(a, b) || cout3 !== 1'b0) begin
                errors++;
                $display("FAIL sweep[%0d] display: got %0d/%0d/%0d Z=%b O=%b C=%b want %0d/%0d/%0d Z=%b O=%b C=0",
                         r, hund3, tens3, units3, zero3, ovf3, cout3, r / 100, (r / 10) % 10, r % 10,
                         (r == 0), ref_ovf(a, b));
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset1 = 1'b1; start1 = 1'b0; operand_a1 = 8'd0; operand_b1 = 8'd0; opcode1 = 2'd0;
        reset3 = 1'b1; start3 = 1'b0; operand_a3 = 8'd0; operand_b3 = 8'd0; opcode3 = 2'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        test_reset();
        reset1 = 1'b0;
        reset3 = 1'b0;
        @(negedge clock);
        test_basic();
        test_zero();
        test_busy_ignore();
        test_flags();
        test_reset_mid();
        test_reset_priority();
        test_random();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
